// File: rtl/imm_instr_encoder.sv
// Immediate-format instruction encoder: range-checks the immediate, builds the
// RV32I word and streams it with a word address through a one-entry output stage.
module imm_instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2:0]           op_i,
  input  logic [4:0]           rd_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [31:0]          imm_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ADDR_W-1:0]    out_addr_o,
  output logic [31:0]          out_instr_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 wrap_o
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  localparam logic [2:0] OP_ADDI = 3'd0;
  localparam logic [2:0] OP_SRAI = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  req_t       req;
  logic [0:0] state_q;
  logic       accept, out_hs, legal, in_rng12, in_rng5;
  logic [31:0] enc;

  assign req = '{op: op_i, rd: rd_i, rs1: rs1_i, rs2: rs2_i, imm: imm_i};

  assign in_ready_o  = !rst_i && ((state_q == EMPTY) || out_ready_i);
  assign out_valid_o = (state_q == FULL);
  assign accept      = in_valid_i && in_ready_o;
  assign out_hs      = out_valid_o && out_ready_i;

  // Signed range over the full 32 bits: upper bits must all equal the sign bit.
  assign in_rng12 = (req.imm[31:11] == '0) || (req.imm[31:11] == '1);
  assign in_rng5  = (req.imm[31:5] == '0);

  always_comb begin
    legal = 1'b0;
    enc   = '0;
    case (req.op)
      OP_ADDI: begin
        legal = in_rng12;
        enc   = {req.imm[11:0], req.rs1, 3'b000, req.rd, 7'b0010011};
      end
      OP_SRAI: begin
        legal = in_rng5;
        enc   = {7'b0100000, req.imm[4:0], req.rs1, 3'b101, req.rd, 7'b0010011};
      end
      OP_LW: begin
        legal = in_rng12;
        enc   = {req.imm[11:0], req.rs1, 3'b010, req.rd, 7'b0000011};
      end
      OP_SW: begin
        legal = in_rng12;
        enc   = {req.imm[11:5], req.rs2, req.rs1, 3'b010, req.imm[4:0], 7'b0100011};
      end
      OP_BEQ: begin
        // imm is already in halfword units, so bit 0 of the byte offset is implicit.
        legal = in_rng12;
        enc   = {req.imm[11], req.imm[9:4], req.rs2, req.rs1, 3'b000,
                 req.imm[3:0], req.imm[10], 7'b1100011};
      end
      default: begin
        legal = 1'b0;
        enc   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      out_instr_o <= '0;
      out_addr_o  <= '0;
      err_o       <= 1'b0;
      err_cnt_o   <= '0;
      wrap_o      <= 1'b0;
    end else begin
      wrap_o <= out_hs && (&out_addr_o);
      if (out_hs) out_addr_o <= out_addr_o + ADDR_W'(1);

      if (accept && legal) begin
        out_instr_o <= enc;
        state_q     <= FULL;
      end else if (out_hs) begin
        state_q <= EMPTY;
      end

      err_o <= accept && !legal;
      if (accept && !legal && !(&err_cnt_o)) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
    end
  end

endmodule
